// File: rtl/cpu_pkg.sv
// Shared datapath definitions: forward-select codes and default widths.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Operand source chosen by the forwarding logic; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

endpackage : cpu_pkg

// File: rtl/fwd_detect.sv
// Per-operand forwarding comparator and 3:1 source selector (combinational).
// Ports:
//   addr_i            source register number
//   rf_data_i         register-file read data for addr_i
//   exmem_*_i         EX/MEM write-enable, destination, result
//   memwb_*_i         MEM/WB write-enable, destination, writeback data
//   data_o            selected operand value
//   sel_o             forward-select code for the chosen source
module fwd_detect
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned RADDR_W = REG_W
) (
  input  logic [RADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]   rf_data_i,
  input  logic               exmem_regwrite_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic [WIDTH-1:0]   exmem_result_i,
  input  logic               memwb_regwrite_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic [WIDTH-1:0]   memwb_result_i,
  output logic [WIDTH-1:0]   data_o,
  output fwd_sel_t           sel_o
);

  logic addr_nz;
  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hard-wired, so a latch claiming to write it never forwards.
  assign addr_nz   = (addr_i != '0);
  assign exmem_hit = exmem_regwrite_i && (exmem_rd_i == addr_i) && addr_nz;
  assign memwb_hit = memwb_regwrite_i && (memwb_rd_i == addr_i) && addr_nz;

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    data_o = rf_data_i;
    sel_o  = FWD_RF;
    if (exmem_hit) begin
      data_o = exmem_result_i;
      sel_o  = FWD_EXMEM;
    end else if (memwb_hit) begin
      data_o = memwb_result_i;
      sel_o  = FWD_MEMWB;
    end
  end

endmodule : fwd_detect

// File: rtl/alu_operand_stage.sv
// ID/EX operand-selection stage: forwarding for rs/rt, ALUSrc immediate
// select on operand B, and the ID/EX output registers with stall and flush.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   stall, flush                 hold outputs / insert bubble (flush wins)
//   in_valid                     ID-stage instruction valid
//   rs_addr, rt_addr             source register numbers
//   rdata1, rdata2, imm          register-file data and sign-extended immediate
//   alusrc                       1 = imm on operand B
//   exmem_*, memwb_*             forwarding latch triples
//   out_valid                    registered instruction valid
//   alu_a, alu_b, store_data     registered operands and store data
//   fwd_a, fwd_b                 registered forward-select codes
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned RADDR_W = REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [WIDTH-1:0]   rdata1,
  input  logic [WIDTH-1:0]   rdata2,
  input  logic [WIDTH-1:0]   imm,
  input  logic               alusrc,
  input  logic               exmem_regwrite,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_regwrite,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_result,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [WIDTH-1:0]   store_data,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  fwd_sel_t         rs_sel;
  fwd_sel_t         rt_sel;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] store_q, store_d;
  fwd_sel_t         fwd_a_q, fwd_a_d;
  fwd_sel_t         fwd_b_q, fwd_b_d;

  // Operand A source (rs).
  fwd_detect #(
    .WIDTH   (WIDTH),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs (
    .addr_i           (rs_addr),
    .rf_data_i        (rdata1),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .data_o           (rs_val),
    .sel_o            (rs_sel)
  );

  // Operand B / store-data source (rt).
  fwd_detect #(
    .WIDTH   (WIDTH),
    .RADDR_W (RADDR_W)
  ) u_fwd_rt (
    .addr_i           (rt_addr),
    .rf_data_i        (rdata2),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .data_o           (rt_val),
    .sel_o            (rt_sel)
  );

  // Next-state: flush clears, stall holds, otherwise load (data loads
  // regardless of in_valid; consumers qualify with out_valid).
  always_comb begin
    valid_d = valid_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    store_d = store_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (flush) begin
      valid_d = 1'b0;
      alu_a_d = '0;
      alu_b_d = '0;
      store_d = '0;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else if (!stall) begin
      valid_d = in_valid;
      alu_a_d = rs_val;
      alu_b_d = alusrc ? imm : rt_val;
      store_d = rt_val;
      fwd_a_d = rs_sel;
      fwd_b_d = rt_sel;
    end
  end

  // ID/EX boundary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      store_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      valid_q <= valid_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      store_q <= store_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign store_data = store_q;
  assign fwd_a      = fwd_a_q;
  assign fwd_b      = fwd_b_q;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed vectors push expected
// outputs into a queue; a monitor pops and compares them.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, alusrc;
  logic [4:0]  rs_addr, rt_addr, exmem_rd, memwb_rd;
  logic [31:0] rdata1, rdata2, imm, exmem_result, memwb_result;
  logic        exmem_regwrite, memwb_regwrite;
  logic        out_valid;
  logic [31:0] alu_a, alu_b, store_data;
  logic [1:0]  fwd_a, fwd_b;

  typedef struct {
    string       name;
    logic        ov;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (in_valid),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .imm            (imm),
    .alusrc         (alusrc),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .out_valid      (out_valid),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .store_data     (store_data),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // Monitor: compares DUT outputs against each queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (out_valid !== e.ov || alu_a !== e.a || alu_b !== e.b ||
            store_data !== e.sd || fwd_a !== e.fa || fwd_b !== e.fb) begin
          n_bad++;
          $display("FAIL %s: got ov=%b a=%h b=%h sd=%h fa=%b fb=%b, want ov=%b a=%h b=%h sd=%h fa=%b fb=%b",
                   e.name, out_valid, alu_a, alu_b, store_data, fwd_a, fwd_b,
                   e.ov, e.a, e.b, e.sd, e.fa, e.fb);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input logic ov, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] sd,
                            input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.name = nm; e.ov = ov; e.a = a; e.b = b; e.sd = sd; e.fa = fa; e.fb = fb;
    exp_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; in_valid = 0; alusrc = 0;
    rs_addr = '0; rt_addr = '0; rdata1 = '0; rdata2 = '0; imm = '0;
    exmem_regwrite = 0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst_n = 0;
    #12;
    expect_out("reset_init", 0, 0, 0, 0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1;

    // Plain register-file path.
    in_valid = 1; rdata1 = 32'h11; rdata2 = 32'h22;
    tick();
    expect_out("rf_path", 1, 32'h11, 32'h22, 32'h22, 2'b00, 2'b00);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    #2;
    rst_n = 0;
    #1;
    expect_out("reset_async", 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    rst_n = 1;
    clr_in();
    in_valid = 1; rdata1 = 32'h11;
    tick();
    expect_out("after_reset", 1, 32'h11, 0, 0, 2'b00, 2'b00);

    // Double hazard: EX/MEM wins.
    clr_in();
    in_valid = 1; rs_addr = 5; rt_addr = 5; rdata1 = 32'h100; rdata2 = 32'h200;
    exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    tick();
    expect_out("double_hazard", 1, 32'hAAAA, 32'hAAAA, 32'hAAAA, 2'b10, 2'b10);

    // MEM/WB hit on rs; rt match with EX/MEM write disabled uses RF.
    clr_in();
    in_valid = 1; rs_addr = 3; rt_addr = 4; rdata1 = 32'h33; rdata2 = 32'h44;
    exmem_regwrite = 0; exmem_rd = 4; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBBBB;
    tick();
    expect_out("memwb_only", 1, 32'hBBBB, 32'h44, 32'h44, 2'b01, 2'b00);

    // Register 0 never forwarded.
    clr_in();
    in_valid = 1;
    exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
    memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'hBEEF;
    tick();
    expect_out("reg_zero", 1, 0, 0, 0, 2'b00, 2'b00);

    // Immediate on B; store data and fwd_b still follow rt.
    clr_in();
    in_valid = 1; alusrc = 1; imm = 32'hFFFF_FFFC; rs_addr = 1; rdata1 = 32'h9;
    rt_addr = 7; rdata2 = 32'h77;
    memwb_regwrite = 1; memwb_rd = 7; memwb_result = 32'h1234;
    tick();
    expect_out("imm_path", 1, 32'h9, 32'hFFFF_FFFC, 32'h1234, 2'b00, 2'b01);

    // Data loads even when in_valid=0.
    clr_in();
    rs_addr = 2; exmem_regwrite = 1; exmem_rd = 2; exmem_result = 32'h55;
    rdata2 = 32'h66;
    tick();
    expect_out("invalid_load", 0, 32'h55, 32'h66, 32'h66, 2'b10, 2'b00);

    // Stall holds for three cycles while inputs (including hazards) change.
    clr_in();
    in_valid = 1; rdata1 = 32'h1;
    tick();
    expect_out("stall_load", 1, 32'h1, 0, 0, 2'b00, 2'b00);
    stall = 1; rdata1 = 32'h2; in_valid = 0;
    rs_addr = 6; exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall_hold%0d", i), 1, 32'h1, 0, 0, 2'b00, 2'b00);
    end
    stall = 0; in_valid = 1; rs_addr = 0; exmem_regwrite = 0;
    tick();
    expect_out("stall_release", 1, 32'h2, 0, 0, 2'b00, 2'b00);

    // Flush overrides stall.
    rdata2 = 32'h5; rt_addr = 9; memwb_regwrite = 1; memwb_rd = 9; memwb_result = 32'h77;
    tick();
    expect_out("pre_flush", 1, 32'h2, 32'h77, 32'h77, 2'b00, 2'b01);
    stall = 1; flush = 1;
    tick();
    expect_out("flush_over_stall", 0, 0, 0, 0, 2'b00, 2'b00);

    // Reset during stall; stall has no lingering effect afterwards.
    clr_in();
    in_valid = 1; rdata1 = 32'hC0;
    tick();
    expect_out("pre_stall_rst", 1, 32'hC0, 0, 0, 2'b00, 2'b00);
    stall = 1; rdata1 = 32'hC1;
    #2;
    rst_n = 0;
    #1;
    expect_out("reset_in_stall", 0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    rst_n = 1; stall = 0;
    tick();
    expect_out("after_stall_rst", 1, 32'hC1, 0, 0, 2'b00, 2'b00);

    // Drain: the monitor consumes synchronously, so the queue should be empty.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_alu_operand_stage
